// File: rtl/secded_pkg.sv
// secded_pkg: SECDED geometry helpers and the decoder's error-class encoding.
package secded_pkg;
  typedef enum logic [1:0] {CLEAN, SB, SB_P0, DB} err_class_e;
  function automatic int calc_m(input int k);
    int m = 1;
    while ((1 << m) < m + k + 1) m++;
    return m;
  endfunction
  function automatic int calc_n(input int k);
    return calc_m(k) + k;
  endfunction
  // Hamming position of data bit idx: the idx-th non-power-of-two position from 3 up.
  function automatic int data_pos(input int idx);
    int c = 0;
    int r = 0;
    for (int p = 3; p <= idx + 40; p++)
      if ((p & (p - 1)) != 0) begin
        if (c == idx && r == 0) r = p;
        c++;
      end
    return r;
  endfunction
endpackage

// File: rtl/secded_syndrome.sv
// secded_syndrome: combinational Hamming syndrome S and overall parity P of a codeword.
module secded_syndrome import secded_pkg::*; #(
  parameter int K = 4,
  localparam int M = calc_m(K),
  localparam int N = calc_n(K)
) (
  input  logic [N:0] code,
  output logic [M:0] sp
);
  logic [M-1:0] s;
  always_comb begin
    s = '0;
    for (int j = 0; j < M; j++)
      for (int i = 1; i <= N; i++)
        if (((i >> j) & 1) != 0) s[j] = s[j] ^ code[i];
  end
  assign sp = {s, ^code};
endmodule

// File: rtl/secded_stream_decoder.sv
// secded_stream_decoder: two-stage valid/ready SECDED corrector with saturating error counters and first-error log.
module secded_stream_decoder import secded_pkg::*; #(
  parameter int K = 4,
  parameter int CNT_W = 16,
  localparam int M = calc_m(K),
  localparam int N = calc_n(K)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [N:0]       s_code_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [K-1:0]     m_data_o,
  output logic             m_sb_err_o,
  output logic             m_db_err_o,
  output logic             m_sb_fix_o,
  output logic [M:0]       m_syndrome_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] sb_cnt_o,
  output logic [CNT_W-1:0] db_cnt_o,
  output logic             log_valid_o,
  output logic [M:0]       log_syndrome_o
);
  logic rdy_en, s1_valid, s1_load, m_load, fire, par;
  logic [M:0] sp, s1_sp;
  logic [M-1:0] syn_s;
  logic [K-1:0] raw, s1_raw, fixed;
  err_class_e cls;
  secded_syndrome #(.K(K)) u_syn (.code(s_code_i), .sp(sp));
  for (genvar i = 0; i < K; i++) begin : g_raw
    assign raw[i] = s_code_i[data_pos(i)];
  end
  assign m_load = !m_valid_o || m_ready_i;
  assign s1_load = !s1_valid || m_load;
  // Held low through reset and for the first cycle after it.
  assign s_ready_o = rdy_en && s1_load;
  assign syn_s = s1_sp[M:1];
  assign par = s1_sp[0];
  assign cls = par ? (syn_s == '0 ? SB_P0 : (int'(syn_s) <= N ? SB : DB))
                   : (syn_s == '0 ? CLEAN : DB);
  for (genvar i = 0; i < K; i++) begin : g_fix
    assign fixed[i] = s1_raw[i] ^ (cls == SB && syn_s == M'(data_pos(i)));
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rdy_en   <= 1'b0;
      s1_valid <= 1'b0;
      s1_raw   <= '0;
      s1_sp    <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (s1_load) s1_valid <= s_valid_i && s_ready_o;
      if (s_valid_i && s_ready_o) begin
        s1_raw <= raw;
        s1_sp  <= sp;
      end
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      m_valid_o    <= 1'b0;
      m_data_o     <= '0;
      m_sb_err_o   <= 1'b0;
      m_db_err_o   <= 1'b0;
      m_sb_fix_o   <= 1'b0;
      m_syndrome_o <= '0;
    end else if (m_load) begin
      m_valid_o <= s1_valid;
      if (s1_valid) begin
        m_data_o     <= fixed;
        m_sb_err_o   <= cls == SB || cls == SB_P0;
        m_db_err_o   <= cls == DB;
        m_sb_fix_o   <= cls == SB || cls == SB_P0;
        m_syndrome_o <= s1_sp;
      end
    end
  assign fire = m_valid_o && m_ready_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sb_cnt_o       <= '0;
      db_cnt_o       <= '0;
      log_valid_o    <= 1'b0;
      log_syndrome_o <= '0;
    end else if (cnt_clr_i) begin
      sb_cnt_o       <= '0;
      db_cnt_o       <= '0;
      log_valid_o    <= 1'b0;
      log_syndrome_o <= '0;
    end else if (fire) begin
      if (m_sb_err_o && ~&sb_cnt_o) sb_cnt_o <= sb_cnt_o + 1'b1;
      if (m_db_err_o && ~&db_cnt_o) db_cnt_o <= db_cnt_o + 1'b1;
      if ((m_sb_err_o || m_db_err_o) && !log_valid_o) begin
        log_valid_o    <= 1'b1;
        log_syndrome_o <= m_syndrome_o;
      end
    end
endmodule

// File: tb/tb_secded_stream_decoder.sv
// tb_secded_stream_decoder: directed checks of decode, flow control, counters, log and reset (K=4).
module tb_secded_stream_decoder;
  logic clk = 0, rst = 1, s_valid = 0, m_ready = 1, cnt_clr = 0;
  logic [7:0] s_code = '0;
  logic s_ready, m_valid, m_sb, m_db, m_fix, log_valid;
  logic [3:0] m_data, m_syn, log_syn;
  logic [15:0] sb_cnt, db_cnt;
  logic s_ready2, m_valid2, m_sb2, m_db2, m_fix2, log_valid2;
  logic [3:0] m_data2, m_syn2, log_syn2;
  logic [1:0] sb_cnt2, db_cnt2;
  int checks = 0, errs = 0;
  logic [7:0] bp_code [5] = '{8'h0F, 8'h33, 8'h3C, 8'h55, 8'h5A};
  logic [3:0] bp_data [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
  always #5 clk = ~clk;
  secded_stream_decoder #(.K(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready), .s_code_i(s_code),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_sb_err_o(m_sb),
    .m_db_err_o(m_db), .m_sb_fix_o(m_fix), .m_syndrome_o(m_syn), .cnt_clr_i(cnt_clr),
    .sb_cnt_o(sb_cnt), .db_cnt_o(db_cnt), .log_valid_o(log_valid), .log_syndrome_o(log_syn));
  secded_stream_decoder #(.K(4), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready2), .s_code_i(s_code),
    .m_valid_o(m_valid2), .m_ready_i(m_ready), .m_data_o(m_data2), .m_sb_err_o(m_sb2),
    .m_db_err_o(m_db2), .m_sb_fix_o(m_fix2), .m_syndrome_o(m_syn2), .cnt_clr_i(cnt_clr),
    .sb_cnt_o(sb_cnt2), .db_cnt_o(db_cnt2), .log_valid_o(log_valid2), .log_syndrome_o(log_syn2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] c);
    int n = 0;
    s_valid = 1;
    s_code = c;
    @(negedge clk);
    while (!s_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("send_ready", s_ready, 1);
    @(posedge clk);
    #1 s_valid = 0;
  endtask
  task automatic wait_out(input int lat);
    int n = 1;
    @(negedge clk);
    while (!m_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("out_valid", m_valid, 1);
    if (lat != 0) chk("latency", n, lat);
  endtask
  task automatic expect_out(input string tag, input logic [3:0] d, input logic sb, input logic db,
                            input logic fix, input logic [3:0] syn);
    wait_out(2);
    chk({tag, "_data"}, m_data, d);
    chk({tag, "_flags"}, {m_sb, m_db, m_fix}, {sb, db, fix});
    chk({tag, "_syn"}, m_syn, syn);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int si, got;
    logic stall, hs_in;
    logic [3:0] pd;
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_cnts", {sb_cnt, db_cnt}, 0);
    chk("rst_log", log_valid, 0);
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1 chk("ready_after_rst", s_ready, 1);
    send(8'hAA);
    expect_out("clean", 4'hB, 0, 0, 0, 4'h0);
    chk("clean_cnts", {sb_cnt, db_cnt}, 0);
    chk("clean_log", log_valid, 0);
    send(8'h8A);
    expect_out("sb", 4'hB, 1, 0, 1, 4'hB);
    chk("sb_cnt", sb_cnt, 1);
    chk("sb_log", {log_valid, log_syn}, {1'b1, 4'hB});
    cnt_clr = 1;
    @(posedge clk);
    #1 cnt_clr = 0;
    chk("clr", {sb_cnt, log_valid}, 0);
    send(8'hAB);
    expect_out("p0", 4'hB, 1, 0, 1, 4'h1);
    chk("p0_log", {log_valid, log_syn}, {1'b1, 4'h1});
    send(8'hAC);
    expect_out("db", 4'hB, 0, 1, 0, 4'h6);
    chk("db_cnts", {sb_cnt, db_cnt}, {16'd1, 16'd1});
    chk("db_log_kept", {log_valid, log_syn}, {1'b1, 4'h1});
    si = 0;
    got = 0;
    stall = 0;
    pd = '0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      s_valid = si < 5;
      s_code = bp_code[si < 5 ? si : 4];
      m_ready = c >= 4;
      @(negedge clk);
      if (c == 2 || c == 3) chk("bp_ready_low", s_ready, 0);
      if (stall) chk("bp_stable", {m_valid, m_data, m_sb, m_db, m_fix}, {1'b1, pd, 3'b000});
      if (m_valid && m_ready) begin
        chk("bp_data", m_data, bp_data[got]);
        got++;
      end
      stall = m_valid && !m_ready;
      pd = m_data;
      hs_in = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (hs_in) si++;
    end
    s_valid = 0;
    m_ready = 1;
    chk("bp_count", got, 5);
    cnt_clr = 1;
    @(posedge clk);
    #1 cnt_clr = 0;
    for (int i = 0; i < 5; i++) begin
      send(8'h8A);
      expect_out("sat", 4'hB, 1, 0, 1, 4'hB);
    end
    chk("sat_cnt2", sb_cnt2, 3);
    chk("sat_cnt16", sb_cnt, 5);
    chk("sat_log2", log_valid2, 1);
    send(8'h8A);
    wait_out(2);
    cnt_clr = 1;
    @(posedge clk);
    #1 cnt_clr = 0;
    chk("clr_win_cnt", {sb_cnt, sb_cnt2}, 0);
    chk("clr_win_log", {log_valid, log_valid2}, 0);
    send(8'h8A);
    expect_out("pre_rst", 4'hB, 1, 0, 1, 4'hB);
    chk("pre_rst_cnt", sb_cnt, 1);
    m_ready = 0;
    send(8'hAA);
    send(8'h0F);
    chk("full_m_valid", m_valid, 1);
    rst = 1;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_cnt", {sb_cnt, db_cnt, log_valid}, 0);
    @(posedge clk);
    #1 rst = 0;
    m_ready = 1;
    @(posedge clk);
    #1;
    send(8'hAA);
    expect_out("post_rst", 4'hB, 0, 0, 0, 4'h0);
    @(negedge clk);
    chk("drained", m_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/secded_stream_decoder.md
Name: secded_stream_decoder

Overview:
- Clocked, pipelined SECDED checker/corrector on the receive side of the Hamming link.
- Accepts (K+M+1)-bit codewords produced by the team's Hamming encoder over a valid/ready stream.
- Classifies each codeword as clean, single-error (corrected) or double-error, and emits corrected data with flags and syndrome.
- Keeps saturating error counters and a first-error syndrome log for scrubbing and monitor software.

Parameters:
- K, 4: data bits per word.
- M, smallest m with 2**m >= m+K+1 (3 for K=4): Hamming parity bits; derived, never overridden.
- N, M+K: Hamming positions 1..N; codeword width is N+1.
- CNT_W, 16: width of each error counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- s_valid_i  input  1  input codeword valid.
- s_ready_o  output  1  decoder can accept a codeword.
- s_code_i  input  N+1  codeword; bit 0 = overall parity, bits 1..N = Hamming positions.
- m_valid_o  output  1  output beat valid.
- m_ready_i  input  1  downstream accepts the beat.
- m_data_o  output  K  corrected data.
- m_sb_err_o  output  1  single-bit error detected.
- m_db_err_o  output  1  double/uncorrectable error detected.
- m_sb_fix_o  output  1  single-bit error corrected.
- m_syndrome_o  output  M+1  bits [M:1] = Hamming syndrome S, bit 0 = overall parity P.
- cnt_clr_i  input  1  synchronous clear of counters and log.
- sb_cnt_o  output  CNT_W  accepted single-error beats, saturating.
- db_cnt_o  output  CNT_W  accepted double-error beats, saturating.
- log_valid_o  output  1  first-error log holds an entry.
- log_syndrome_o  output  M+1  syndrome of the first error since reset or clear.

Behaviour:
- Codeword layout:
  - Power-of-two positions 2^j hold parity p_j, even parity over all positions with bit j set.
  - Data bits occupy the remaining positions in ascending order; d[0] is at position 3.
  - Bit 0 is the XOR of positions 1..N.
- Pipeline: two registered stages.
  - Stage 1 computes S and P and registers them with the codeword.
  - Stage 2 registers corrected data and flags onto the m_* outputs.
  - Latency is 2 cycles from handshake (s_valid_i && s_ready_o) to m_valid_o, with no backpressure.
- Flow control:
  - A stage loads when it is empty or its downstream is unloading in the same cycle.
  - s_ready_o = !s1_valid || stage 2 loadable; this is combinational and may depend on m_ready_i.
  - Full throughput is one beat per cycle.
  - No beat is dropped or duplicated.
  - m_* outputs stay stable while m_valid_o && !m_ready_i.
- Classification:
  - S=0, P=0: clean; all flags 0.
  - S!=0, P=1, S<=N: flip position S; sb_err=1, sb_fix=1.
  - S=0, P=1: the error is in bit 0; sb_err=1, sb_fix=1, data unchanged.
  - S!=0, P=0: double error; db_err=1, data passed uncorrected.
  - S>N, P=1 (possible only when N < 2^M-1): uncorrectable; db_err=1, sb_fix=0, data uncorrected.
  - sb_err and db_err are never both 1.
- Counters:
  - Increment on output handshake (m_valid_o && m_ready_i) when the matching flag is set.
  - Saturate at all-ones.
  - cnt_clr_i clears both counters and the log; clear wins over a same-cycle increment or capture.
- Log: on the first accepted beat with sb_err or db_err while log_valid_o=0, capture m_syndrome_o and set log_valid_o. Later errors do not overwrite the entry.
- Reset, including mid-stream: all valids 0, outputs 0, counters 0, log_valid_o 0. In-flight beats are discarded. s_ready_o=1 one cycle after reset deasserts.

Decomposition:
- Package secded_pkg: calc_m function, N derivation, and the error-class encoding (CLEAN, SB, SB_P0, DB).
- Combinational sub-module secded_syndrome computes {S,P}.
- Correction and data extraction are generate loops inline in the top.
- Counters and log live in the top.

Test Plan (K=4, N=7, CNT_W=16 unless stated):
- Clean word: s_code_i=8'hAA (data 4'hB), m_ready_i=1 → 2 cycles later m_data_o=4'hB, all flags 0, m_syndrome_o=4'h0, counters 0.
- Single data error: 8'h8A (position 5 flipped) → m_data_o=4'hB, sb_err=1, sb_fix=1, syndrome 4'hB, sb_cnt_o=1, log_valid_o=1, log_syndrome_o=4'hB.
- Overall-parity error: 8'hAB → data 4'hB, sb_err=1, sb_fix=1, syndrome 4'h1. Then double error 8'hAC (positions 1 and 2) → db_err=1, sb_fix=0, syndrome 4'h6, db_cnt_o=1, log still 4'h1 (only after the single-error test that set log 4'hB has been cleared with cnt_clr_i).
- Backpressure: stream 5 beats back-to-back with m_ready_i=0 for 4 cycles → s_ready_o drops after 2 beats are held, outputs stay stable, all 5 emerge in order with no loss.
- Saturation/clear: CNT_W=2, send 5 single-error beats → sb_cnt_o=3. Assert cnt_clr_i on the same cycle as a 6th error handshake → sb_cnt_o=0 and log_valid_o=0.
- Reset mid-stream: assert rst_i with both stages full → m_valid_o=0 immediately and counters 0. After release, 8'hAA decodes normally.
